// File: rtl/wb_master_seq.sv
// wb_master_seq: single-outstanding Wishbone classic master sequencer.
// Turns one valid/ready command into one Wishbone cycle and returns the
// result on a one-cycle response strobe. After each cycle the master stays in
// RECOVER until the slave has released ack/err. This keeps a stale ack from
// being taken as the answer to the next command.
// Build option: define WB_MASTER_TIMEOUT_EN to add an ACTIVE-state watchdog.
// The watchdog aborts a cycle with an error response after TIMEOUT_CYCLES
// cycles without ack or err.
module wb_master_seq #(
    parameter int ADR_W          = 32,
    parameter int DAT_W          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [DAT_W-1:0] cmd_dat_i,
    output logic             rsp_valid_o,
    output logic [DAT_W-1:0] rsp_dat_o,
    output logic             rsp_err_o,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [ADR_W-1:0] adr_o,
    output logic [DAT_W-1:0] dat_o,
    input  logic [DAT_W-1:0] dat_i,
    input  logic             ack_i,
    input  logic             err_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RECOVER
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               cyc_next;
    logic               stb_next;
    logic               we_next;
    logic [ADR_W-1:0]   adr_next;
    logic [DAT_W-1:0]   dat_next;
    logic               rsp_valid_next;
    logic               rsp_err_next;
    logic [DAT_W-1:0]   rsp_dat_next;
    logic               accept;
    logic               timeout_hit;

    // Ready is gated by a lingering ack/err, so a new cycle never starts
    // while the previous slave is still answering.
    assign cmd_ready_o = (state == IDLE) & ~ack_i & ~err_i & ~rst_i;
    assign accept      = cmd_valid_i & cmd_ready_o;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] timeout_cnt;

    // Watchdog counts ACTIVE cycles and restarts from zero on every entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeout_cnt <= '0;
        end else if (state == ACTIVE) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end else begin
            timeout_cnt <= '0;
        end
    end

    assign timeout_hit = (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State and registered bus/response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= '0;
            dat_o       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_dat_o   <= '0;
        end else begin
            state       <= state_next;
            cyc_o       <= cyc_next;
            stb_o       <= stb_next;
            we_o        <= we_next;
            adr_o       <= adr_next;
            dat_o       <= dat_next;
            rsp_valid_o <= rsp_valid_next;
            rsp_err_o   <= rsp_err_next;
            rsp_dat_o   <= rsp_dat_next;
        end
    end

    // Next-state and next-output logic. Bus fields hold their values unless
    // changed, and the response fields fall back to zero every cycle.
    always_comb begin
        state_next     = state;
        cyc_next       = cyc_o;
        stb_next       = stb_o;
        we_next        = we_o;
        adr_next       = adr_o;
        dat_next       = dat_o;
        rsp_valid_next = 1'b0;
        rsp_err_next   = 1'b0;
        rsp_dat_next   = '0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    cyc_next   = 1'b1;
                    stb_next   = 1'b1;
                    we_next    = cmd_we_i;
                    adr_next   = cmd_adr_i;
                    dat_next   = cmd_we_i ? cmd_dat_i : '0;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (err_i || ack_i || timeout_hit) begin
                    rsp_valid_next = 1'b1;
                    cyc_next       = 1'b0;
                    stb_next       = 1'b0;
                    state_next     = RECOVER;
                    if (err_i || !ack_i) begin
                        rsp_err_next = 1'b1;
                    end else if (!we_o) begin
                        rsp_dat_next = dat_i;
                    end
                end
            end
            RECOVER: begin
                if (!ack_i && !err_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_master_seq.sv
// tb_wb_master_seq: scoreboard bench for wb_master_seq against a small
// wb_slave_1-like model. The model acks one cycle after it sees stb and
// releases ack one cycle after stb falls. It can also answer with ack+err
// and hold err, or stay silent.
module tb_wb_master_seq;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int TO    = 8;
    localparam logic [DAT_W-1:0] RD_DATA = 32'hBBBB0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_we = 1'b0;
    logic [ADR_W-1:0] cmd_adr = '0;
    logic [DAT_W-1:0] cmd_dat = '0;
    logic             rsp_valid;
    logic [DAT_W-1:0] rsp_dat;
    logic             rsp_err;
    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_out;
    logic [DAT_W-1:0] slv_dat;
    logic             slv_ack = 1'b0;
    logic             slv_err = 1'b0;

    int slave_mode = 0;
    int err_hold   = 0;
    int vectors    = 0;
    int miscompares = 0;

    logic [DAT_W:0] exp_q[$];

    wb_master_seq #(
        .ADR_W(ADR_W),
        .DAT_W(DAT_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr),
        .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid),
        .rsp_dat_o(rsp_dat),
        .rsp_err_o(rsp_err),
        .cyc_o(cyc),
        .stb_o(stb),
        .we_o(we),
        .adr_o(adr),
        .dat_o(dat_out),
        .dat_i(slv_dat),
        .ack_i(slv_ack),
        .err_i(slv_err)
    );

    always #5 clk = ~clk;

    // Slave model: mode 0 normal, mode 1 ack+err with err held two extra
    // cycles, mode 2 silent.
    assign slv_dat = slv_ack ? RD_DATA : '0;

    always @(posedge clk) begin
        if (slave_mode == 2) begin
            slv_ack  <= 1'b0;
            slv_err  <= 1'b0;
            err_hold <= 0;
        end else if (cyc === 1'b1 && stb === 1'b1) begin
            slv_ack  <= 1'b1;
            slv_err  <= (slave_mode == 1);
            err_hold <= (slave_mode == 1) ? 2 : 0;
        end else begin
            slv_ack <= 1'b0;
            if (slv_err && err_hold > 0) begin
                err_hold <= err_hold - 1;
            end else begin
                slv_err <= 1'b0;
            end
        end
    end

    // Scoreboard: every response strobe pops the oldest expected result.
    always @(negedge clk) begin
        logic [DAT_W:0] expv;
        if (rsp_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL rsp_unexpected: got err=%b dat=%h, required no response", rsp_err, rsp_dat);
            end else begin
                expv = exp_q.pop_front();
                if ({rsp_err, rsp_dat} !== expv) begin
                    miscompares++;
                    $display("[TB] FAIL rsp_data: got err=%b dat=%h, required err=%b dat=%h",
                             rsp_err, rsp_dat, expv[DAT_W], expv[DAT_W-1:0]);
                end
            end
        end
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, required finish before time limit");
        $fatal(1, "[TB] time limit expired");
    end

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({cyc, stb, we, rsp_valid, rsp_err} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b, required 00000", {cyc, stb, we, rsp_valid, rsp_err});
        end
        vectors++;
        if ({adr, dat_out, rsp_dat} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got adr=%h dat=%h rsp_dat=%h, required zeros", adr, dat_out, rsp_dat);
        end
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ready_low: got %b, required 0", cmd_ready);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready_high: got %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_read();
        int n;
        int gap;
        @(negedge clk);
        slave_mode = 0;
        cmd_we = 1'b0;
        cmd_adr = 32'h10;
        cmd_dat = 32'h12345678;
        cmd_valid = 1'b1;
        #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL read_ready: got %b, required 1", cmd_ready);
        end
        exp_q.push_back({1'b0, RD_DATA});
        @(negedge clk);
        cmd_valid = 1'b0;
        vectors++;
        if ({cyc, stb, we, adr, dat_out} !== {1'b1, 1'b1, 1'b0, 32'h10, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL read_bus: got cyc=%b stb=%b we=%b adr=%h dat=%h, required 1 1 0 00000010 00000000",
                     cyc, stb, we, adr, dat_out);
        end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 20 || cyc !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL read_rsp: got wait=%0d cyc=%b, required response with cyc=0", n, cyc);
        end
        gap = 0;
        while (cmd_ready !== 1'b1 && gap < 20) begin
            @(negedge clk);
            gap++;
            if (gap == 1) begin
                vectors++;
                if (rsp_valid !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL read_rsp_pulse: got %b, required 0", rsp_valid);
                end
            end
        end
        vectors++;
        if (gap !== 2 || slv_ack !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL read_ready_return: got gap=%0d ack=%b, required gap=2 ack=0", gap, slv_ack);
        end
    endtask

    task automatic test_write();
        int n;
        @(negedge clk);
        slave_mode = 0;
        cmd_we = 1'b1;
        cmd_adr = 32'h20;
        cmd_dat = 32'hDEADBEEF;
        cmd_valid = 1'b1;
        #1;
        if (cmd_ready === 1'b1) begin
            exp_q.push_back({1'b0, 32'h0});
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            vectors++;
            if ({cyc, stb, we, adr, dat_out} !== {1'b1, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF}) begin
                miscompares++;
                $display("[TB] FAIL write_bus: got cyc=%b stb=%b we=%b adr=%h dat=%h, required 1 1 1 00000020 deadbeef",
                         cyc, stb, we, adr, dat_out);
            end
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $display("[TB] FAIL write_rsp: got no response in %0d cycles, required one", n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int pushed;
        int rises;
        int seen;
        logic prev_cyc;
        pushed = 0;
        rises = 0;
        seen = 0;
        prev_cyc = 1'b0;
        @(negedge clk);
        slave_mode = 0;
        cmd_we = 1'b0;
        cmd_adr = 32'h30;
        cmd_dat = 32'h0;
        cmd_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            #1;
            if (cmd_valid && cmd_ready === 1'b1) begin
                exp_q.push_back({1'b0, RD_DATA});
                pushed++;
            end
            @(negedge clk);
            if (pushed == 3) cmd_valid = 1'b0;
            if (cyc === 1'b1 && prev_cyc === 1'b0) begin
                rises++;
                vectors++;
                if (slv_ack !== 1'b0 || stb !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_stale_ack: got ack=%b stb=%b at cycle start, required ack=0 stb=1", slv_ack, stb);
                end
            end
            prev_cyc = cyc;
            if (rsp_valid === 1'b1) seen++;
            if (seen == 3 && cmd_ready === 1'b1) break;
        end
        cmd_valid = 1'b0;
        vectors++;
        if (rises !== 3 || seen !== 3 || pushed !== 3) begin
            miscompares++;
            $display("[TB] FAIL b2b_count: got cycles=%0d responses=%0d accepts=%0d, required 3 3 3", rises, seen, pushed);
        end
    endtask

    task automatic test_error();
        int n;
        int gap;
        @(negedge clk);
        slave_mode = 1;
        cmd_we = 1'b0;
        cmd_adr = 32'h40;
        cmd_valid = 1'b1;
        #1;
        if (cmd_ready === 1'b1) begin
            exp_q.push_back({1'b1, 32'h0});
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 20 || rsp_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL err_rsp: got wait=%0d err=%b, required error response", n, rsp_err);
        end
        gap = 0;
        while (cmd_ready !== 1'b1 && gap < 20) begin
            @(negedge clk);
            gap++;
            if (slv_err === 1'b1 && (cyc !== 1'b0 || cmd_ready !== 1'b0)) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL err_recover_hold: got cyc=%b ready=%b while err high, required 0 0", cyc, cmd_ready);
            end
        end
        vectors++;
        if (gap !== 4) begin
            miscompares++;
            $display("[TB] FAIL err_recover_len: got gap=%0d, required 4", gap);
        end
        slave_mode = 0;
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        slave_mode = 0;
        cmd_we = 1'b0;
        cmd_adr = 32'h44;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({cyc, stb, rsp_valid} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL rstmid_drop: got cyc=%b stb=%b rsp=%b, required 0 0 0", cyc, stb, rsp_valid);
        end
        vectors++;
        if (slv_ack === 1'b1 && cmd_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_gate: got ready=%b with ack high, required 0", cmd_ready);
        end
        n = 0;
        while (cmd_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 10 || slv_ack !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_ready: got wait=%0d ack=%b, required ready with ack=0", n, slv_ack);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc_hi;
        int seen;
        cyc_hi = 0;
        seen = 0;
        @(negedge clk);
        slave_mode = 2;
        cmd_we = 1'b0;
        cmd_adr = 32'h50;
        cmd_valid = 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
        #1;
        if (cmd_ready === 1'b1) begin
            exp_q.push_back({1'b1, 32'h0});
        end
`endif
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (rsp_valid === 1'b1) begin
                seen++;
                break;
            end
            if (cyc === 1'b1) cyc_hi++;
            @(negedge clk);
        end
`ifdef WB_MASTER_TIMEOUT_EN
        vectors++;
        if (seen !== 1 || cyc_hi !== TO || rsp_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout_abort: got rsp=%0d active=%0d err=%b, required 1 %0d 1", seen, cyc_hi, rsp_err, TO);
        end
        repeat (3) @(negedge clk);
`else
        vectors++;
        if (seen !== 0 || cyc_hi !== 100 || cyc !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL no_timeout_wait: got rsp=%0d active=%0d cyc=%b, required 0 100 1", seen, cyc_hi, cyc);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif
        slave_mode = 0;
        repeat (2) @(negedge clk);
    endtask

    // Scenario sequence, final scoreboard drain check and summary.
    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_error();
        test_reset_mid();
        test_timeout();
        repeat (2) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
